// File: rtl/game_screen_sequencer.sv
// Screen sequencer for the game top level: walks title -> play -> over on key
// presses, handles game-over entry and the over-screen auto-return, emits flap
// pulses during play, and owns the free-running seed counter and the seed
// capture / random-generator reset when play starts.
module game_screen_sequencer #(
  parameter int NUM_SCREENS  = 3,
  parameter int SCREEN_W     = 2,
  parameter int SEED_W       = 32,
  parameter int PLAY_SCREEN  = 1,
  parameter int OVER_SCREEN  = 2,
  parameter int WRAP         = 1,
  parameter int PLAY_ADVANCE = 0,
  parameter int OVER_TIMEOUT = 0,
  parameter int TIMEOUT_W    = 32
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [1:0]          key_state,
  output logic                key_ack,
  input  logic                game_over,
  output logic [SCREEN_W-1:0] screen,
  output logic                screen_changed,
  output logic                bg_scroll,
  output logic                flap,
  output logic                random_reset,
  output logic [SEED_W-1:0]   seed,
  output logic [SEED_W-1:0]   seed_latched
);

  localparam logic [SCREEN_W-1:0]  LAST_SCR  = SCREEN_W'(NUM_SCREENS - 1);
  localparam logic [SCREEN_W-1:0]  PLAY_SCR  = SCREEN_W'(PLAY_SCREEN);
  localparam logic [SCREEN_W-1:0]  OVER_SCR  = SCREEN_W'(OVER_SCREEN);
  localparam logic [TIMEOUT_W-1:0] TO_LAST   = TIMEOUT_W'((OVER_TIMEOUT > 0) ? OVER_TIMEOUT - 1 : 0);
  localparam bit                   TO_EN     = (OVER_TIMEOUT > 0);
  localparam bit                   WRAP_EN   = (WRAP != 0);
  localparam bit                   FLAP_MODE = (PLAY_ADVANCE == 0);

  // Key handshake: one ack cycle per accepted event; key_state is ignored
  // while the ack is high so the PS2 side has a cycle to clear it.
  typedef enum logic {HS_IDLE = 1'b0, HS_ACK = 1'b1} hs_state_t;

  hs_state_t               hs_state;
  hs_state_t               hs_next;
  logic                    key_event;
  logic                    key_press;
  logic [SCREEN_W-1:0]     screen_nxt;
  logic                    flap_nxt;
  logic                    leave_zero;
  logic [TIMEOUT_W-1:0]    tmo_cnt;

  // Handshake state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) hs_state <= HS_IDLE;
    else         hs_state <= hs_next;
  end

  // Handshake next state and event decode.
  always_comb begin
    hs_next   = hs_state;
    key_event = 1'b0;
    case (hs_state)
      HS_IDLE: begin
        if (key_state != 2'd0) begin
          key_event = 1'b1;
          hs_next   = HS_ACK;
        end
      end
      HS_ACK:  hs_next = HS_IDLE;
      default: hs_next = HS_IDLE;
    endcase
  end

  assign key_ack   = (hs_state == HS_ACK);
  assign key_press = key_event && (key_state == 2'd1);

  // Next screen: game-over beats a press, a press beats the over timeout.
  always_comb begin
    screen_nxt = screen;
    flap_nxt   = 1'b0;
    if ((screen == PLAY_SCR) && game_over) begin
      screen_nxt = OVER_SCR;
    end else if (key_press) begin
      if ((screen == PLAY_SCR) && FLAP_MODE) flap_nxt = 1'b1;
      else if (screen < LAST_SCR)            screen_nxt = screen + 1'b1;
      else if (WRAP_EN)                      screen_nxt = '0;
    end else if (TO_EN && (screen == OVER_SCR) && (tmo_cnt == TO_LAST)) begin
      screen_nxt = '0;
    end
    leave_zero = (screen == '0) && (screen_nxt != '0);
  end

  // Screen, pulse outputs, seed counter, seed capture and over-screen timer.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      screen         <= '0;
      screen_changed <= 1'b0;
      bg_scroll      <= 1'b0;
      flap           <= 1'b0;
      random_reset   <= 1'b0;
      seed           <= '0;
      seed_latched   <= '0;
      tmo_cnt        <= '0;
    end else begin
      screen         <= screen_nxt;
      screen_changed <= (screen_nxt != screen);
      bg_scroll      <= (screen_nxt == PLAY_SCR);
      flap           <= flap_nxt;
      random_reset   <= leave_zero;
      seed           <= seed + 1'b1;
      if (leave_zero) seed_latched <= seed;
      if ((screen_nxt == OVER_SCR) && (screen != OVER_SCR)) tmo_cnt <= '0;
      else if (screen == OVER_SCR)                          tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule
